// File: rtl/rect_loop_pkg.sv
// Shared types and helpers for the rectangle-loop checkerboard swap engine.
package rect_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    CHECK,
    SWAP,
    DONE
  } rect_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned col_len);
    return r * col_len + c;
  endfunction

endpackage

// File: rtl/rect_lfsr16.sv
// 16-bit Galois LFSR candidate source; advances only when step is high.
module rect_lfsr16
  import rect_loop_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/rect_swap_ctrl.sv
// Checkerboard swap scheduler: draws LFSR corner pairs and flips valid rectangles.
// Optional reject statistics counter built when RECT_SWAP_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; loads matrix and swap count
// PICK  | latch r1,r2,c1,c2 from LFSR, advance LFSR
// CHECK | evaluate candidate, count attempt
// SWAP  | flip the four corners, count swap
// DONE  | one-cycle done pulse
module rect_swap_ctrl
  import rect_loop_pkg::*;
#(
  parameter int          ROW_LEN       = 4,
  parameter int          COL_LEN       = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          ATTEMPT_LIMIT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                instr,
  input  logic [ROW_LEN*COL_LEN-1:0] in_mat,
  output logic                       busy,
  output logic                       done,
  output logic                       abort,
  output logic [ROW_LEN*COL_LEN-1:0] out_mat,
  output logic [11:0]                swaps,
  output logic [15:0]                rejects
);

  localparam int MW = ROW_LEN * COL_LEN;
  localparam int IW = $clog2(MW);
  localparam int RW = $clog2(ROW_LEN);
  localparam int CW = $clog2(COL_LEN);
  localparam int AW = $clog2(ATTEMPT_LIMIT + 1);
  localparam int PW = 2 * RW + 2 * CW;
  localparam logic [AW-1:0] ATT_LIM = AW'(ATTEMPT_LIMIT);

  if (PW > 16) begin : g_bad_size
    $error("rect_swap_ctrl: corner indices need more than 16 LFSR bits");
  end

  rect_state_e   state_q, state_d;
  logic [MW-1:0] mat_q, mat_d;
  logic [11:0]   n_q, n_d;
  logic [11:0]   swaps_q, swaps_d;
  logic [AW-1:0] att_q, att_d;
  logic          abort_q, abort_d;
  logic [RW-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [CW-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [15:0]   lfsr_state;
  logic [IW-1:0] i11, i12, i21, i22;
  logic          rows_ok, cols_ok, cand_ok;
  logic [MW-1:0] flip_mask;
  logic          unused_bits;

  rect_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (state_q == PICK),
    .state (lfsr_state)
  );

  assign unused_bits = ^{instr[31:12], lfsr_state};

  // Power-of-two dimensions make every drawn index legal.
  if (ROW_LEN == (1 << RW)) begin : g_rows_full
    assign rows_ok = 1'b1;
  end else begin : g_rows_part
    assign rows_ok = (r1_q < RW'(ROW_LEN)) && (r2_q < RW'(ROW_LEN));
  end

  if (COL_LEN == (1 << CW)) begin : g_cols_full
    assign cols_ok = 1'b1;
  end else begin : g_cols_part
    assign cols_ok = (c1_q < CW'(COL_LEN)) && (c2_q < CW'(COL_LEN));
  end

  assign i11 = IW'(idx(32'(r1_q), 32'(c1_q), COL_LEN));
  assign i12 = IW'(idx(32'(r1_q), 32'(c2_q), COL_LEN));
  assign i21 = IW'(idx(32'(r2_q), 32'(c1_q), COL_LEN));
  assign i22 = IW'(idx(32'(r2_q), 32'(c2_q), COL_LEN));

  assign cand_ok = rows_ok && cols_ok && (r1_q != r2_q) && (c1_q != c2_q) &&
                   (mat_q[i11] == mat_q[i22]) && (mat_q[i12] == mat_q[i21]) &&
                   (mat_q[i11] != mat_q[i12]);

  always_comb begin
    flip_mask      = '0;
    flip_mask[i11] = 1'b1;
    flip_mask[i12] = 1'b1;
    flip_mask[i21] = 1'b1;
    flip_mask[i22] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    n_d     = n_q;
    swaps_d = swaps_q;
    att_d   = att_q;
    abort_d = abort_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mat_d   = in_mat;
          n_d     = instr[11:0];
          swaps_d = '0;
          att_d   = '0;
          abort_d = 1'b0;
          state_d = (instr[11:0] == 12'd0) ? DONE : PICK;
        end
      end
      PICK: begin
        r1_d    = lfsr_state[RW-1:0];
        r2_d    = lfsr_state[2*RW-1:RW];
        c1_d    = lfsr_state[2*RW+CW-1:2*RW];
        c2_d    = lfsr_state[PW-1:2*RW+CW];
        state_d = CHECK;
      end
      CHECK: begin
        att_d = att_q + AW'(1);
        if (cand_ok) begin
          state_d = SWAP;
        end else if (att_d == ATT_LIM) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = PICK;
        end
      end
      SWAP: begin
        mat_d   = mat_q ^ flip_mask;
        swaps_d = swaps_q + 12'd1;
        if (swaps_d == n_q) begin
          state_d = DONE;
        end else if (att_q == ATT_LIM) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = PICK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      n_q     <= '0;
      swaps_q <= '0;
      att_q   <= '0;
      abort_q <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      n_q     <= n_d;
      swaps_q <= swaps_d;
      att_q   <= att_d;
      abort_q <= abort_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

`ifdef RECT_SWAP_STATS_EN
  logic [15:0] rejects_q, rejects_d;

  always_comb begin
    rejects_d = rejects_q;
    if (state_q == IDLE && start) begin
      rejects_d = '0;
    end else if (state_q == CHECK && !cand_ok && rejects_q != 16'hFFFF) begin
      rejects_d = rejects_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rejects_q <= '0;
    else     rejects_q <= rejects_d;
  end

  assign rejects = rejects_q;
`else
  assign rejects = '0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign abort   = abort_q;
  assign out_mat = mat_q;
  assign swaps   = swaps_q;

endmodule

// File: tb/tb_rect_swap_ctrl.sv
// Directed bench for rect_swap_ctrl with a small reference model of the swap run.
module tb_rect_swap_ctrl;
  import rect_loop_pkg::*;

  localparam int          R     = 4;
  localparam int          C     = 4;
  localparam int          LIMIT = 4096;
  localparam int          WAITMAX = 20000;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] instr;
  logic [15:0] in_mat;
  logic        busy, done, abort;
  logic [15:0] out_mat;
  logic [11:0] swaps;
  logic [15:0] rejects;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;

  rect_swap_ctrl #(
    .ROW_LEN(R), .COL_LEN(C), .LFSR_SEED(SEED), .ATTEMPT_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .in_mat(in_mat),
    .busy(busy), .done(done), .abort(abort), .out_mat(out_mat),
    .swaps(swaps), .rejects(rejects)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit sums_equal(input logic [15:0] a, input logic [15:0] b);
    for (int r = 0; r < R; r++) begin
      int pa = 0, pb = 0;
      for (int c = 0; c < C; c++) begin
        pa += int'(a[r*C+c]);
        pb += int'(b[r*C+c]);
      end
      if (pa != pb) return 1'b0;
    end
    for (int c = 0; c < C; c++) begin
      int pa = 0, pb = 0;
      for (int r = 0; r < R; r++) begin
        pa += int'(a[r*C+c]);
        pb += int'(b[r*C+c]);
      end
      if (pa != pb) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference run: predicts result, counts and start-to-done latency; advances m_lfsr.
  task automatic model_run(input logic [15:0] mi, input int n, output logic [15:0] mo,
                           output int sw, output int rej, output int lat, output logic ab);
    int att, r1, r2, c1, c2;
    logic b11, b12, b21, b22;
    mo = mi; sw = 0; rej = 0; lat = 1; ab = 1'b0; att = 0;
    if (n == 0) return;
    forever begin
      r1 = int'(m_lfsr[1:0]);
      r2 = int'(m_lfsr[3:2]);
      c1 = int'(m_lfsr[5:4]);
      c2 = int'(m_lfsr[7:6]);
      m_lfsr = lfsr_next(m_lfsr);
      att++;
      lat += 2;
      b11 = mo[r1*C+c1]; b12 = mo[r1*C+c2];
      b21 = mo[r2*C+c1]; b22 = mo[r2*C+c2];
      if (r1 != r2 && c1 != c2 && b11 == b22 && b12 == b21 && b11 != b12) begin
        mo[r1*C+c1] = ~b11; mo[r1*C+c2] = ~b12;
        mo[r2*C+c1] = ~b21; mo[r2*C+c2] = ~b22;
        lat += 1;
        sw++;
        if (sw == n) break;
        if (att == LIMIT) begin ab = 1'b1; break; end
      end else begin
        rej++;
        if (att == LIMIT) begin ab = 1'b1; break; end
      end
    end
  endtask

  // Starts a run and returns at the negedge where done is seen (or the wait expires).
  task automatic run(input logic [15:0] mi, input logic [31:0] ins, output int lat);
    @(negedge clk);
    in_mat = mi; instr = ins; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < WAITMAX) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  function automatic int exp_rej(input int rej);
`ifdef RECT_SWAP_STATS_EN
    return rej;
`else
    return 0 * rej;
`endif
  endfunction

  logic [15:0] m_mat, ref_mat;
  int          m_sw, m_rej, m_lat, lat, ref_lat, k;
  logic        m_ab;

  initial begin
    rst = 1'b1; start = 1'b0; instr = '0; in_mat = '0; m_lfsr = SEED;
    repeat (2) @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_abort",   32'(abort),   32'd0);
    check("rst_out_mat", 32'(out_mat), 32'd0);
    check("rst_swaps",   32'(swaps),   32'd0);
    check("rst_rejects", 32'(rejects), 32'd0);
    rst = 1'b0;

    // N == 0, upper instruction bits must be ignored
    run(16'h1234, 32'hFFFF_F000, lat);
    check("n0_latency", 32'(lat),     32'd1);
    check("n0_busy",    32'(busy),    32'd1);
    check("n0_out_mat", 32'(out_mat), 32'h1234);
    check("n0_swaps",   32'(swaps),   32'd0);
    check("n0_abort",   32'(abort),   32'd0);
    @(negedge clk);
    check("n0_done_pulse", 32'(done), 32'd0);
    check("n0_busy_drop",  32'(busy), 32'd0);

    // Checkerboard, single swap
    model_run(16'h5A5A, 1, m_mat, m_sw, m_rej, m_lat, m_ab);
    ref_mat = m_mat; ref_lat = m_lat;
    run(16'h5A5A, 32'd1, lat);
    check("n1_latency", 32'(lat),                       32'(m_lat));
    check("n1_out_mat", 32'(out_mat),                   32'(m_mat));
    check("n1_swaps",   32'(swaps),                     32'd1);
    check("n1_rejects", 32'(rejects),                   32'(exp_rej(m_rej)));
    check("n1_bitdiff", 32'($countones(out_mat ^ 16'h5A5A)), 32'd4);
    check("n1_sums",    32'(sums_equal(out_mat, 16'h5A5A)), 32'd1);

    // Checkerboard, 100 swaps
    model_run(16'h5A5A, 100, m_mat, m_sw, m_rej, m_lat, m_ab);
    run(16'h5A5A, 32'd100, lat);
    check("n100_swaps",   32'(swaps),   32'd100);
    check("n100_out_mat", 32'(out_mat), 32'(m_mat));
    check("n100_rejects", 32'(rejects), 32'(exp_rej(m_rej)));
    check("n100_sums",    32'(sums_equal(out_mat, 16'h5A5A)), 32'd1);
    check("n100_latency", 32'(lat), 32'(m_lat));
    check("n100_lat_bound", 32'(lat <= 301 + 2 * m_rej), 32'd1);
    check("n100_abort",   32'(abort),   32'd0);

    // Start re-pulsed while busy with a different request must be ignored
    model_run(16'h5A5A, 3, m_mat, m_sw, m_rej, m_lat, m_ab);
    @(negedge clk);
    start = 1'b1; in_mat = 16'h5A5A; instr = 32'd3;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        start = 1'b1; instr = 32'd7; in_mat = 16'h0000;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < WAITMAX);
    check("busy_start_latency", 32'(lat),     32'(m_lat));
    check("busy_start_out_mat", 32'(out_mat), 32'(m_mat));
    check("busy_start_swaps",   32'(swaps),   32'd3);
    @(negedge clk);
    check("busy_start_idle", 32'(busy), 32'd0);

    // All-zero matrix: no candidate is ever valid, so the attempt budget runs out
    model_run(16'h0000, 5, m_mat, m_sw, m_rej, m_lat, m_ab);
    run(16'h0000, 32'd5, lat);
    check("abort_latency", 32'(lat),     32'(2 * LIMIT + 1));
    check("abort_flag",    32'(abort),   32'd1);
    check("abort_out_mat", 32'(out_mat), 32'd0);
    check("abort_swaps",   32'(swaps),   32'd0);
    check("abort_rejects", 32'(rejects), 32'(exp_rej(LIMIT)));
    repeat (3) @(negedge clk);
    check("abort_held", 32'(abort), 32'd1);
    run(16'h00FF, 32'd0, lat);
    check("abort_cleared", 32'(abort),   32'd0);
    check("abort_clr_mat", 32'(out_mat), 32'h00FF);

    // Reset asserted during SWAP, then a fresh run from the seed
    @(negedge clk);
    start = 1'b1; in_mat = 16'h5A5A; instr = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (dut.state_q != SWAP && k < WAITMAX) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached_swap", 32'(dut.state_q == SWAP), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_out_mat", 32'(out_mat), 32'd0);
    check("mid_rst_swaps",   32'(swaps),   32'd0);
    @(negedge clk);
    check("mid_rst_done",    32'(done),    32'd0);
    check("mid_rst_abort",   32'(abort),   32'd0);
    check("mid_rst_rejects", 32'(rejects), 32'd0);
    rst = 1'b0;
    m_lfsr = SEED;
    run(16'h5A5A, 32'd1, lat);
    check("rerun_latency", 32'(lat),     32'(ref_lat));
    check("rerun_out_mat", 32'(out_mat), 32'(ref_mat));
    check("rerun_swaps",   32'(swaps),   32'd1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_swap_ctrl.md
# rect_swap_ctrl

Sequential controller for the rectangle-loop checkerboard swap engine. It loads a ROW_LEN x COL_LEN binary matrix and draws candidate corner pairs (r1,c1)/(r2,c2) from an on-chip LFSR. Each candidate that forms a checkerboard unit has its four corners flipped, which preserves every row and column sum. It repeats until the requested number of successful swaps completes or the attempt budget runs out. It replaces the unclocked swap_locate/swapping chain with a cycle-accurate, synthesizable scheduler.

## Interface
- ROW_LEN, 4, matrix rows (2..16)
- COL_LEN, 4, matrix columns (2..16)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
- ATTEMPT_LIMIT, 4096, maximum candidate evaluations per run before abort
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request; sampled only in IDLE
- instr  in  32  instruction word; [11:0] = requested swap count N; [31:12] ignored
- in_mat  in  ROW_LEN*COL_LEN  input matrix, bit r*COL_LEN+c = M[r][c]; sampled on the accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse at end of run
- abort  out  1  set with done when ATTEMPT_LIMIT is hit; held until next accepted start
- out_mat  out  ROW_LEN*COL_LEN  working matrix; holds the result after done
- swaps  out  12  successful swaps in current/last run
- rejects  out  16  rejected candidates in current/last run (see Configuration)

## Operation
- States: IDLE, PICK, CHECK, SWAP, DONE.
- IDLE: on start, out_mat<=in_mat, N<=instr[11:0], swaps/rejects/attempt counter/abort cleared, go PICK. If N==0, go DONE instead.
- PICK: latch r1,r2 (RW=$clog2(ROW_LEN) bits each) and c1,c2 (CW bits each) from the low LFSR bits, packed in order {c2,c1,r2,r1} starting at bit 0. Require 2*RW+2*CW <= 16 (elaboration check). Advance the LFSR. Go CHECK.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Steps only in PICK.
- CHECK: a candidate is valid iff all of the following hold: r1,r2 < ROW_LEN; c1,c2 < COL_LEN; r1!=r2; c1!=c2; M[r1][c1]==M[r2][c2]; M[r1][c2]==M[r2][c1]; M[r1][c1]!=M[r1][c2].
  - Each CHECK increments the attempt counter.
  - Valid candidate: go SWAP.
  - Invalid candidate: rejects++ (saturating); go DONE with abort=1 if attempts==ATTEMPT_LIMIT, else go PICK.
- SWAP: invert the four corner bits of out_mat and increment swaps. Go DONE if swaps==N, else apply the same limit test and then go PICK.
- DONE: done=1 for one cycle, then IDLE. busy drops on the IDLE cycle.
- start while busy is ignored. in_mat and instr changes after acceptance have no effect.

## Timing
- Reset values: busy=0, done=0, abort=0, out_mat=0, swaps=0, rejects=0. State=IDLE, LFSR=LFSR_SEED.
- N==0: start at cycle 0 -> DONE at cycle 1 -> done high in cycle 1.
- Rejected attempt costs 2 cycles (PICK+CHECK). Successful attempt costs 3 cycles (PICK+CHECK+SWAP).
- Minimum latency for N swaps: 3N+1 cycles from accepted start to done.
- out_mat updates only in the SWAP cycle; it is stable in all other cycles.
- rst asserted mid-run: immediate return to reset values. No done pulse; the partial result is lost.
- The LFSR is not reseeded by start. Consecutive runs continue the sequence.

## Configuration
- RECT_SWAP_STATS_EN defined: the rejects counter is implemented and drives the rejects port.
- Not defined: rejects is tied to 0 and its counter is removed. The attempt counter and abort logic remain in both cases.

## Structure
- Package rect_loop_pkg holds:
  - state enum rect_state_e {IDLE, PICK, CHECK, SWAP, DONE}
  - LFSR tap constant and a function idx(r,c,COL_LEN) returning the flattened bit position
- One sub-module: rect_lfsr16 (clk, rst, step, seed param, 16-bit state out).
- Checkerboard test and flip logic live inside rect_swap_ctrl.

## Test plan
- instr=0, start -> done pulse 1 cycle after start, out_mat==in_mat, swaps==0, abort==0.
- in_mat=16'h0000 (all zero), N=5 -> abort=1 after exactly ATTEMPT_LIMIT CHECKs, out_mat==0, swaps==0, rejects==ATTEMPT_LIMIT (STATS_EN).
- in_mat=16'h5A5A (4x4 checkerboard), N=1 -> done, swaps==1, exactly 4 bits differ from input, all row/column popcounts unchanged.
- in_mat=16'h5A5A, N=100 -> swaps==100, row/column sums preserved, done within 3*100+1+2*rejects cycles.
- start re-pulsed while busy with different instr -> ignored; result matches the first request.
- rst raised in the middle of SWAP state -> next cycle all outputs at reset values; a following start with same inputs and seed reproduces the cycle-exact reference run.
